// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle processor control path:
// opcodes, funct codes, ALU op codes, FSM states and decode payload.
package cpu_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned OP_W   = 6;
    localparam int unsigned ALU_W  = 3;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    localparam logic [OP_W-1:0] FN_ADD = 6'h20;
    localparam logic [OP_W-1:0] FN_SUB = 6'h22;
    localparam logic [OP_W-1:0] FN_AND = 6'h24;
    localparam logic [OP_W-1:0] FN_OR  = 6'h25;
    localparam logic [OP_W-1:0] FN_SLT = 6'h2A;

    localparam logic [ALU_W-1:0] ALU_ADD = 3'd0;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'd1;
    localparam logic [ALU_W-1:0] ALU_AND = 3'd2;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'd3;
    localparam logic [ALU_W-1:0] ALU_SLT = 3'd4;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        IC_RTYPE  = 3'd0,
        IC_IMM    = 3'd1,
        IC_LOAD   = 3'd2,
        IC_STORE  = 3'd3,
        IC_BRANCH = 3'd4,
        IC_JUMP   = 3'd5
    } iclass_t;

    typedef struct packed {
        logic [ALU_W-1:0] alu_op;
        logic             alu_src_imm;
        logic             wb_sel;
        logic             rd_is_rt;
        iclass_t          iclass;
        logic             legal;
    } dec_t;

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction decoder: opcode/funct to ALU controls,
// writeback select, destination select, instruction class and legality.
module instr_decode
    import cpu_pkg::*;
(
    input  logic [OP_W-1:0] op,
    input  logic [OP_W-1:0] funct,
    output dec_t            dec
);

    always_comb begin
        dec.alu_op      = ALU_ADD;
        dec.alu_src_imm = 1'b0;
        dec.wb_sel      = 1'b0;
        dec.rd_is_rt    = 1'b0;
        dec.iclass      = IC_RTYPE;
        dec.legal       = 1'b0;

        case (op)
            OP_RTYPE: begin
                dec.legal = 1'b1;
                case (funct)
                    FN_ADD:  dec.alu_op = ALU_ADD;
                    FN_SUB:  dec.alu_op = ALU_SUB;
                    FN_AND:  dec.alu_op = ALU_AND;
                    FN_OR:   dec.alu_op = ALU_OR;
                    FN_SLT:  dec.alu_op = ALU_SLT;
                    default: dec.legal  = 1'b0;
                endcase
            end
            OP_ADDI: begin
                dec.iclass      = IC_IMM;
                dec.alu_src_imm = 1'b1;
                dec.rd_is_rt    = 1'b1;
                dec.legal       = 1'b1;
            end
            OP_LW: begin
                dec.iclass      = IC_LOAD;
                dec.alu_src_imm = 1'b1;
                dec.rd_is_rt    = 1'b1;
                dec.wb_sel      = 1'b1;
                dec.legal       = 1'b1;
            end
            OP_SW: begin
                dec.iclass      = IC_STORE;
                dec.alu_src_imm = 1'b1;
                dec.legal       = 1'b1;
            end
            OP_BEQ: begin
                dec.iclass = IC_BRANCH;
                dec.alu_op = ALU_SUB;
                dec.legal  = 1'b1;
            end
            OP_J: begin
                dec.iclass = IC_JUMP;
                dec.legal  = 1'b1;
            end
            default: dec.legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle control unit: instruction register, PC, datapath latches and
// the FETCH/DECODE/EXEC/MEM/WB sequencer with state-decoded strobes.
module mc_ctrl_fsm
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_ready,
    input  logic [XLEN-1:0]   alu_result,
    input  logic              alu_zero,
    output logic              mem_req,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   pc,
    output logic [REG_AW-1:0] rs,
    output logic [REG_AW-1:0] rt,
    output logic [REG_AW-1:0] rd,
    output logic              reg_we,
    output logic              wb_sel,
    output logic [XLEN-1:0]   wb_data,
    output logic [XLEN-1:0]   imm_ext,
    output logic              alu_src_imm,
    output logic [ALU_W-1:0]  alu_op,
    output logic              illegal
);

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] ir_q, ir_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] alu_q, alu_d;
    logic [XLEN-1:0] mdr_q, mdr_d;
    logic            illegal_q, illegal_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic            reg_we_q, reg_we_d;

    dec_t            dec;
    logic [XLEN-1:0] imm_sext;
    logic [XLEN-1:0] branch_tgt;
    logic [XLEN-1:0] jump_tgt;
    logic            fetch_done;
    logic            mem_done;

    instr_decode u_decode (
        .op    (ir_q[31:26]),
        .funct (ir_q[5:0]),
        .dec   (dec)
    );

    assign imm_sext   = {{16{ir_q[15]}}, ir_q[15:0]};
    assign branch_tgt = XLEN'(pc_q + {imm_sext[XLEN-3:0], 2'b00});
    assign jump_tgt   = {pc_q[31:28], ir_q[25:0], 2'b00};

    // A handshake completes only while the registered request is visible,
    // so a ready arriving in the first cycle after reset is ignored.
    assign fetch_done = (state_q == ST_FETCH) && mem_req_q && mem_ready;
    assign mem_done   = (state_q == ST_MEM)   && mem_req_q && mem_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            addr_q    <= '0;
            alu_q     <= '0;
            mdr_q     <= '0;
            illegal_q <= 1'b0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            reg_we_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            addr_q    <= addr_d;
            alu_q     <= alu_d;
            mdr_q     <= mdr_d;
            illegal_q <= illegal_d;
            mem_req_q <= mem_req_d;
            mem_we_q  <= mem_we_d;
            reg_we_q  <= reg_we_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        addr_d    = addr_q;
        alu_d     = alu_q;
        mdr_d     = mdr_q;
        illegal_d = illegal_q;

        case (state_q)
            ST_FETCH: begin
                if (fetch_done) begin
                    ir_d    = mem_rdata;
                    pc_d    = XLEN'(pc_q + 32'd4);
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (dec.legal) begin
                    state_d = ST_EXEC;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = ST_HALT;
                end
            end
            ST_EXEC: begin
                case (dec.iclass)
                    IC_BRANCH: begin
                        if (alu_zero) begin
                            pc_d = branch_tgt;
                        end
                        state_d = ST_FETCH;
                    end
                    IC_JUMP: begin
                        pc_d    = jump_tgt;
                        state_d = ST_FETCH;
                    end
                    IC_LOAD, IC_STORE: begin
                        addr_d  = alu_result;
                        state_d = ST_MEM;
                    end
                    default: begin
                        alu_d   = alu_result;
                        state_d = ST_WB;
                    end
                endcase
            end
            ST_MEM: begin
                if (mem_done) begin
                    if (dec.iclass == IC_LOAD) begin
                        mdr_d   = mem_rdata;
                        state_d = ST_WB;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_WB:   state_d = ST_FETCH;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase

        // Strobes are flopped copies of the state they belong to.
        mem_req_d = (state_d == ST_FETCH) || (state_d == ST_MEM);
        mem_we_d  = (state_d == ST_MEM) && (dec.iclass == IC_STORE);
        reg_we_d  = (state_d == ST_WB);
    end

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign reg_we      = reg_we_q;
    assign illegal     = illegal_q;
    assign pc          = pc_q;
    assign mem_addr    = (state_q == ST_MEM) ? addr_q : pc_q;
    assign rs          = ir_q[25:21];
    assign rt          = ir_q[20:16];
    assign rd          = dec.rd_is_rt ? ir_q[20:16] : ir_q[15:11];
    assign imm_ext     = imm_sext;
    assign alu_op      = dec.alu_op;
    assign alu_src_imm = dec.alu_src_imm;
    assign wb_sel      = dec.wb_sel;
    assign wb_data     = dec.wb_sel ? mdr_q : alu_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: acts as memory and ALU, predicts each instruction's
// accesses, writeback, cycle count and next PC from the ISA rules.
`timescale 1ns/1ps
module tb_mc_ctrl_fsm;

    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        mem_req, mem_we, reg_we, wb_sel, alu_src_imm, illegal;
    logic [31:0] mem_addr, pc, wb_data, imm_ext;
    logic [4:0]  rs, rt, rd;
    logic [2:0]  alu_op;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] m_pc;
    logic [5:0]  fn_tab [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    logic [2:0]  fn_op  [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};

    always #5 clk = ~clk;

    mc_ctrl_fsm #(.RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .alu_result(alu_result), .alu_zero(alu_zero), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .pc(pc), .rs(rs), .rt(rt), .rd(rd),
        .reg_we(reg_we), .wb_sel(wb_sel), .wb_data(wb_data), .imm_ext(imm_ext),
        .alu_src_imm(alu_src_imm), .alu_op(alu_op), .illegal(illegal)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_reg_we", 32'(reg_we), 0);
        rst = 1'b0;
        @(negedge clk);
        check("rel_mem_req", 32'(mem_req), 1);
        check("rel_pc", pc, RPC);
        check("rel_illegal", 32'(illegal), 0);
        m_pc = RPC;
    endtask

    // Runs one instruction starting at a negedge where a fetch request is
    // visible; returns at the negedge where the next fetch request appears.
    task automatic run_instr(input logic [31:0] instr, input int fwait, input int mwait,
                             input logic [31:0] ares, input logic azero,
                             input logic [31:0] ldata, input bit abort_mem);
        logic [5:0]  op, fn;
        logic [31:0] imm, pc4, pc_next, exp_wb;
        logic [4:0]  exp_rd;
        logic [2:0]  exp_aop;
        bit          legal, is_load, is_store, writes, exp_imm, chk_aop, fetched, done, aborted;
        int          base, exp_acc, n_acc, cyc, waited, post, we_cnt, we_at, exp_cyc;

        op = instr[31:26]; fn = instr[5:0];
        imm = {{16{instr[15]}}, instr[15:0]};
        pc4 = m_pc + 32'd4;
        pc_next = pc4;
        legal = 1; is_load = 0; is_store = 0; writes = 0; chk_aop = 1;
        exp_imm = 0; exp_aop = 3'd0; exp_rd = instr[15:11]; base = 0;
        case (op)
            6'h00: begin
                base = 4; writes = 1; legal = 0;
                for (int i = 0; i < 5; i++)
                    if (fn == fn_tab[i]) begin legal = 1; exp_aop = fn_op[i]; end
            end
            6'h08: begin base = 4; writes = 1; exp_imm = 1; exp_rd = instr[20:16]; end
            6'h23: begin base = 5; writes = 1; exp_imm = 1; is_load = 1; exp_rd = instr[20:16]; end
            6'h2B: begin base = 4; exp_imm = 1; is_store = 1; end
            6'h04: begin base = 3; exp_aop = 3'd1; if (azero) pc_next = pc4 + (imm << 2); end
            6'h02: begin base = 3; chk_aop = 0; pc_next = {pc4[31:28], instr[25:0], 2'b00}; end
            default: legal = 0;
        endcase
        exp_wb  = is_load ? ldata : ares;
        exp_acc = (is_load || is_store) ? 2 : 1;
        exp_cyc = base + fwait + ((exp_acc == 2) ? mwait : 0);

        alu_result = ares; alu_zero = azero;
        n_acc = 0; cyc = 0; waited = 0; post = 0; we_cnt = 0; we_at = 0;
        fetched = 0; done = 0; aborted = 0;
        for (int k = 0; k < 64 && !done; k++) begin
            if (legal && mem_req && n_acc == exp_acc) begin
                done = 1;
            end else begin
                cyc++;
                mem_ready = 1'b0;
                mem_rdata = $urandom();
                if (fetched) begin
                    post++;
                    check("rs_stable", 32'(rs), 32'(instr[25:21]));
                    check("rt_stable", 32'(rt), 32'(instr[20:16]));
                    check("imm_stable", imm_ext, imm);
                    if (legal && chk_aop && post == 2) begin
                        check("exec_alu_op", 32'(alu_op), 32'(exp_aop));
                        check("exec_src_imm", 32'(alu_src_imm), 32'(exp_imm));
                    end
                end
                if (reg_we) begin
                    we_cnt++; we_at = cyc;
                    check("wb_rd", 32'(rd), 32'(exp_rd));
                    check("wb_data", wb_data, exp_wb);
                    check("wb_sel", 32'(wb_sel), 32'(is_load));
                end
                if (!legal && fetched) begin
                    check("halt_mem_req", 32'(mem_req), 0);
                    if (post >= 2) check("halt_illegal", 32'(illegal), 1);
                    if (cyc >= 22) done = 1;
                end else if (mem_req && n_acc == 0) begin
                    if (waited == 0) begin
                        check("fetch_addr", mem_addr, m_pc);
                        check("fetch_we", 32'(mem_we), 0);
                    end
                    if (waited < fwait) waited++;
                    else begin
                        mem_ready = 1'b1; mem_rdata = instr;
                        n_acc = 1; waited = 0; fetched = 1;
                    end
                end else if (mem_req && n_acc == 1) begin
                    check("data_addr", mem_addr, ares);
                    check("data_we", 32'(mem_we), 32'(is_store));
                    if (abort_mem && waited == 1) begin
                        rst = 1'b1;
                        @(negedge clk);
                        rst = 1'b0;
                        check("abort_mem_req", 32'(mem_req), 0);
                        check("abort_mem_we", 32'(mem_we), 0);
                        mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
                        @(negedge clk);
                        mem_ready = 1'b0;
                        check("abort_refetch_req", 32'(mem_req), 1);
                        check("abort_refetch_addr", mem_addr, RPC);
                        check("abort_ir_kept_rs", 32'(rs), 0);
                        check("abort_ir_kept_imm", imm_ext, 0);
                        m_pc = RPC;
                        aborted = 1; done = 1;
                    end else if (waited < mwait) waited++;
                    else begin
                        mem_ready = 1'b1; mem_rdata = ldata;
                        n_acc = 2; waited = 0;
                    end
                end
                if (!done) @(negedge clk);
            end
        end
        check("instr_done", 32'(done), 1);
        if (legal && !aborted) begin
            check("cycles", 32'(cyc), 32'(exp_cyc));
            check("we_count", 32'(we_cnt), 32'(writes));
            if (writes) check("we_cycle", 32'(we_at), 32'(exp_cyc));
            check("next_pc", pc, pc_next);
            check("no_illegal", 32'(illegal), 0);
            m_pc = pc_next;
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom();
        case ($urandom_range(0, 5))
            0: begin r[31:26] = 6'h00; r[5:0] = fn_tab[$urandom_range(0, 4)]; end
            1: r[31:26] = 6'h08;
            2: r[31:26] = 6'h23;
            3: r[31:26] = 6'h2B;
            4: r[31:26] = 6'h04;
            default: r[31:26] = 6'h02;
        endcase
        return r;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; mem_ready = 1'b0; mem_rdata = '0; alu_result = '0; alu_zero = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_mem_req", 32'(mem_req), 0);
        check("reset_pc", pc, RPC);
        rst = 1'b0;
        @(negedge clk);
        check("first_mem_req", 32'(mem_req), 1);
        check("first_mem_addr", mem_addr, RPC);
        check("first_mem_we", 32'(mem_we), 0);
        check("first_reg_we", 32'(reg_we), 0);
        check("first_illegal", 32'(illegal), 0);
        check("first_src_imm", 32'(alu_src_imm), 0);
        check("first_wb_sel", 32'(wb_sel), 0);
        check("first_alu_op", 32'(alu_op), 0);
        check("first_imm", imm_ext, 0);
        check("first_wb_data", wb_data, 0);
        m_pc = RPC;

        run_instr(32'h0022_1820, 0, 0, 32'd7, 1'b0, 32'h0, 1'b0);
        check("add_pc", pc, 32'h104);
        run_instr(32'h8C25_0008, 0, 2, 32'h0000_0208, 1'b0, 32'hDEAD_BEEF, 1'b0);

        reset_dut();
        run_instr(32'h1000_FFFF, 0, 0, 32'h0, 1'b1, 32'h0, 1'b0);
        check("beq_taken_pc", pc, 32'h100);
        run_instr(32'h1000_FFFF, 1, 0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("beq_not_taken_pc", pc, 32'h104);

        run_instr(32'hAC22_0010, 0, 3, 32'h0000_0300, 1'b0, 32'h0, 1'b1);
        run_instr(32'h0022_1820, 0, 0, 32'd9, 1'b0, 32'h0, 1'b0);

        for (int n = 0; n < 150; n++)
            run_instr(rand_instr(), $urandom_range(0, 2), $urandom_range(0, 3),
                      $urandom(), 1'($urandom_range(0, 1)), $urandom(), 1'b0);

        run_instr(32'hFC00_0000, 0, 0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("halt_illegal_end", 32'(illegal), 1);
        reset_dut();
        run_instr(32'h0022_1820, 0, 0, 32'd5, 1'b0, 32'h0, 1'b0);
        run_instr(32'h0022_183F, 1, 0, 32'h0, 1'b0, 32'h0, 1'b0);
        reset_dut();
        run_instr(32'h2025_FFFF, 0, 0, 32'h1234_5678, 1'b0, 32'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Multicycle control unit and instruction register for the custom 32-bit processor. It fetches instructions through a ready-handshaked memory port and decodes them into register addresses (`rs`, `rt`, `rd`), the immediate and ALU controls. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and issues a single-cycle write strobe to the register file it feeds.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `mem_rdata` in 32: instruction or load data from memory.
- `mem_ready` in 1: memory completes the access in the current cycle.
- `alu_result` in 32: ALU output, used as the load/store address.
- `alu_zero` in 1: ALU result is zero, used for BEQ.
- `mem_req` out 1: memory access request.
- `mem_we` out 1: store request, qualified by `mem_req`.
- `mem_addr` out 32: `pc` in FETCH; latched address in MEM.
- `pc` out 32: program counter.
- `rs`, `rt` out 5 each: `ir[25:21]` and `ir[20:16]`, always driven from IR.
- `rd` out 5: write destination. `ir[15:11]` for R-type; `ir[20:16]` for LW and ADDI.
- `reg_we` out 1: register-file write strobe.
- `wb_sel` out 1: 0 selects the ALU result, 1 selects the MDR.
- `wb_data` out 32: muxed writeback value.
- `imm_ext` out 32: sign-extended `ir[15:0]`.
- `alu_src_imm` out 1: ALU operand B is `imm_ext`.
- `alu_op` out 3: ADD=0, SUB=1, AND=2, OR=3, SLT=4.
- `illegal` out 1: sticky flag for an illegal opcode.

## Operation
- Instruction format:
  - `op` = `ir[31:26]`.
  - R-type is `op`=0x00, with funct `ir[5:0]`: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT.
  - Other opcodes: 0x08 ADDI, 0x23 LW, 0x2B SW, 0x04 BEQ, 0x02 J.
- States are FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - Drive `mem_req`=1 and `mem_addr`=`pc`; hold until `mem_ready`.
  - On `mem_ready`: `ir`<=`mem_rdata`, `pc`<=`pc`+4, go to DECODE.
- DECODE:
  - Unknown `op`, or R-type with unknown funct: set `illegal`=1 and go to HALT.
  - Otherwise go to EXEC.
- EXEC:
  - `alu_op` and `alu_src_imm` are valid here. ADDI/LW/SW use ADD with the immediate; BEQ uses SUB with the register operand.
  - BEQ: if `alu_zero`, `pc`<=`pc`+(`imm_ext`<<2), using the already-incremented PC. Go to FETCH.
  - J: `pc`<={`pc`[31:28], `ir`[25:0], 2'b00}. Go to FETCH.
  - LW/SW: latch `alu_result` into `addr_q` and go to MEM.
  - R-type/ADDI: latch `alu_result` into `alu_q` and go to WB.
- MEM:
  - Drive `mem_req`=1 and `mem_addr`=`addr_q`; `mem_we`=1 for SW. Hold until `mem_ready`.
  - SW: go to FETCH.
  - LW: latch `mdr`<=`mem_rdata` and go to WB.
- WB:
  - `reg_we`=1 for exactly one cycle; `wb_data` = `wb_sel` ? `mdr` : `alu_q`.
  - Go to FETCH.
- HALT: absorbing; all strobes are 0. Only `rst` leaves it.
- PC arithmetic is modulo 2^32; a wrap from 0xFFFF_FFFC to 0 is legal.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, state FETCH.
  - `ir`, `addr_q`, `alu_q`, `mdr` = 0.
  - `mem_req`, `mem_we`, `reg_we`, `illegal`, `alu_src_imm`, `wb_sel` = 0.
  - `alu_op`=ADD.
- Strobes (`mem_req`, `mem_we`, `reg_we`) are Moore outputs decoded from state only.
- Cycles per instruction with `mem_ready` tied high:
  - R-type/ADDI: 4.
  - LW: 5.
  - SW: 4.
  - BEQ/J: 3.
- Each cycle of `mem_ready` low in FETCH or MEM adds one cycle.
- `rst` mid-access: `mem_req` is 0 on the cycle after the reset edge. The in-flight store is abandoned, and a `mem_ready` arriving in that cycle is ignored.
- `rst` in WB: `reg_we` is 0 on the following cycle.
- `rs`, `rt` and `imm_ext` change only on the FETCH-completion edge and stay stable through DECODE, EXEC, MEM and WB.

## Structure
- Shared package `cpu_pkg`:
  - opcode and funct localparams;
  - `alu_op` codes;
  - state encoding (3-bit);
  - `RESET_PC` default.
- Sub-module `instr_decode`: combinational; maps `op`/funct to `alu_op`, `alu_src_imm`, `wb_sel`, the `rd` select, an instruction class (RTYPE, IMM, LOAD, STORE, BRANCH, JUMP) and a `legal` flag.
- The FSM, PC, IR and datapath latches live in `mc_ctrl_fsm`.

## Test plan
- Reset with `RESET_PC`=0x100, then release:
  - `mem_req`=1 with `mem_addr`=0x100.
  - All other outputs at their reset values.
- ADD r3,r1,r2 (0x00221820) with `mem_ready` high and `alu_result`=7:
  - `reg_we` pulses exactly in cycle 4.
  - `rd`=3, `wb_data`=7, `pc`=0x104.
- LW r5,8(r1) with two wait cycles in MEM and `mem_rdata`=0xDEADBEEF:
  - `mem_addr`=`alu_result` while `mem_req` is high.
  - `reg_we` is asserted with `rd`=5 and `wb_data`=0xDEADBEEF.
  - 7 cycles in total.
- BEQ at `pc`=0x100 with imm=-1:
  - `alu_zero`=1 gives next fetch address 0x100.
  - `alu_zero`=0 gives 0x104.
- Opcode 0x3F:
  - `illegal`=1, state stays HALT, and `mem_req` stays 0 for 20 cycles.
  - `rst` recovers to FETCH at `RESET_PC`.
- Assert `rst` during an SW MEM stall:
  - `mem_we`=0 and `mem_req`=0 on the next cycle.
  - A late `mem_ready` is ignored.
